four_stage_unpacker: RTL
========================

// Module: four_stage_unpacker
// PURPOSE
//  Transmit-side counterpart of the four-stage byte packer: accepts one 32-bit
//  word on Ld and emits it as four 8-bit bytes, one per enabled cycle, through
//  a 4-entry shift pipeline. Sits between a word-wide producer and a
//  byte-serial link/consumer; En is the consumer's per-cycle take/stall.
// PARAMETERS
//  W          8   byte (lane) width in bits
//  N          4   bytes per word; word width = N*W
//  MSB_FIRST  1   1: emit Word[N*W-1 -: W] first; 0: emit Word[W-1:0] first
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      asynchronous, active-low reset (0 = reset)
//  Ld     in   1      load request; Word sampled when Ld && Rdy
//  En     in   1      shift enable; one byte emitted per cycle with En=1 in SHIFT
//  Word   in   N*W    word to serialise
//  Rdy    out  1      combinational: load will be accepted this cycle
//  Q      out  W      current output byte (registered)
//  Q_vld  out  1      Q holds a newly emitted byte this cycle (registered)
//  Done   out  1      1-cycle pulse coincident with last byte of a word
//  Busy   out  1      1 while in SHIFT
//  Drop   out  1      1-cycle pulse: Ld asserted while Rdy=0 (word lost)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, pipeline regs=0, cnt=0, Q=0, Q_vld=0,
//   Done=0, Busy=0, Drop=0. Reset mid-word discards remaining bytes; no Done.
//  States: IDLE, SHIFT. cnt (clog2(N+1) bits) = bytes still to emit.
//  Rdy = (state==IDLE) | (state==SHIFT & cnt==1 & En).
//  IDLE: Ld=1 -> load pipeline S[0..N-1] from Word (S[0] = first byte per
//   MSB_FIRST), cnt<=N, ->SHIFT. Ld=0 -> stay. Q_vld=0. En ignored.
//  SHIFT, En=1: Q<=S[0], Q_vld<=1, S[i]<=S[i+1], S[N-1]<=0, cnt<=cnt-1.
//   If cnt==1: Done<=1; if Ld also 1 -> reload from Word, cnt<=N, stay SHIFT
//   (back-to-back, no bubble); else ->IDLE.
//  SHIFT, En=0: stall; Q holds last value, Q_vld<=0, cnt/S unchanged.
//  Ld while Rdy=0: Word ignored, Drop<=1 next cycle; state unaffected.
//  Latency: Ld accepted at edge k -> first byte valid on Q after edge k+1
//   if En=1 in that cycle; N-byte word needs N enabled cycles.
//  Q_vld, Done, Drop are single-cycle registered pulses; Busy = (state==SHIFT).
//  Q keeps last emitted byte in IDLE (not cleared except by reset).
//  No arithmetic beyond cnt decrement; cnt never wraps (reload or IDLE at 1).
// TESTING
//  1 Reset: rst=0 at t=0, release at 15ns -> all outputs 0, Rdy=1, Busy=0.
//  2 Single word, MSB_FIRST=1: Ld=1 one cycle, Word=32'hA1B2C3D4, En=1 ->
//    Q = A1,B2,C3,D4 on 4 consecutive cycles, Q_vld=1 each, Done with D4, ->IDLE.
//  3 Stall: as 2 but En=0 for 2 cycles after B2 -> Q holds B2, Q_vld=0 for 2
//    cycles, then C3,D4; total 6 cycles from first byte to Done.
//  4 Back-to-back: Word=32'h01020304 then Ld=1 with 32'h05060708 in D-cycle
//    (cnt==1, En=1) -> Q = 01..04,05..08 with no gap, Done twice, Drop=0.
//  5 Overrun: Ld=1 with 32'hFFFFFFFF while cnt=3 -> Drop=1 one cycle, stream
//    of current word unaffected, FF never appears on Q.
//  6 Reset mid-word: rst=0 after second byte -> Q=0, Q_vld=0, IDLE, no Done;
//    after release new Ld with 32'h11223344 emits 11,22,33,44 (MSB_FIRST=0:
//    44,33,22,11 in separate build).

Source files
------------

// File: rtl/four_stage_unpacker.sv
// four_stage_unpacker: serialises one N*W-bit word into N W-bit bytes, one per
// enabled cycle, with back-to-back reload on the last byte and overrun flagging.
//
// state | meaning
// IDLE  | no word in flight; a load is always accepted
// SHIFT | emitting bytes; cnt = bytes still to emit
module four_stage_unpacker #(
    parameter int W         = 8,
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_ld,
    input  logic           i_en,
    input  logic [N*W-1:0] i_word,
    output logic           o_rdy,
    output logic [W-1:0]   o_q,
    output logic           o_q_vld,
    output logic           o_done,
    output logic           o_busy,
    output logic           o_drop
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_N   = CW'(N);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_s [N];
    logic [W-1:0]   w_ld_bytes [N];
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_q;
    logic           r_q_vld;
    logic           r_done;
    logic           r_drop;
    logic           w_last;
    logic           w_shift;
    logic           w_load;

    // The final byte leaving this cycle frees the pipeline for a same-cycle reload.
    assign w_shift = (r_state == SHIFT) && i_en;
    assign w_last  = w_shift && (r_cnt == C_ONE);
    assign o_rdy   = (r_state == IDLE) || w_last;
    assign w_load  = i_ld && o_rdy;

    assign o_q     = r_q;
    assign o_q_vld = r_q_vld;
    assign o_done  = r_done;
    assign o_drop  = r_drop;
    assign o_busy  = (r_state == SHIFT);

    // Slice the incoming word so that entry 0 always holds the first byte out.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_ld_bytes[i] = '0;
            if (MSB_FIRST)
                w_ld_bytes[i] = i_word[(N-1-i)*W +: W];
            else
                w_ld_bytes[i] = i_word[i*W +: W];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state: leave IDLE on any load, return only when the last byte goes without a reload.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_ld) w_state_nxt = SHIFT;
            SHIFT:   if (w_last && !i_ld) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift pipeline, byte counter and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_s[i] <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_q_vld <= 1'b0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_q_vld <= 1'b0;
            r_done  <= 1'b0;
            r_drop  <= i_ld && !o_rdy;
            if (w_shift) begin
                r_q     <= r_s[0];
                r_q_vld <= 1'b1;
                for (int i = 0; i < N-1; i++) r_s[i] <= r_s[i+1];
                r_s[N-1] <= '0;
                r_cnt   <= r_cnt - C_ONE;
                if (r_cnt == C_ONE) r_done <= 1'b1;
            end
            // A load overrides the shift update of the pipeline and counter.
            if (w_load) begin
                for (int i = 0; i < N; i++) r_s[i] <= w_ld_bytes[i];
                r_cnt <= C_N;
            end
        end
    end

endmodule
